// File: rtl/visaccum_stream_if.sv
// -----------------------------------------------------------------------------
// visaccum_stream_if
// Bundles the partial-sum input stream and the finished-visibility output
// stream of visaccum_stream.
//   s_valid/s_first/s_last/s_data : partial-sum input, no backpressure
//   m_valid/m_ready               : output handshake
//   m_first/m_last/m_data         : output word and its component markers
// Modports:
//   master : the side that produces partial sums and consumes results
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface visaccum_stream_if #(
    parameter int IBITS = 7,
    parameter int OBITS = 36
);
    logic             s_valid;
    logic             s_first;
    logic             s_last;
    logic [IBITS-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_first;
    logic             m_last;
    logic [OBITS-1:0] m_data;

    modport master (
        output s_valid, s_first, s_last, s_data, m_ready,
        input  m_valid, m_first, m_last, m_data
    );

    modport slave (
        input  s_valid, s_first, s_last, s_data, m_ready,
        output m_valid, m_first, m_last, m_data
    );
endinterface

// File: rtl/visaccum_stream.sv
// -----------------------------------------------------------------------------
// visaccum_stream
// Final accumulator for correlator partial sums. NSUMS interleaved components
// (real on even addresses, imag on odd) are summed over a variable number of
// passes framed by s_first/s_last. Results of the last pass are queued in an
// ODEPTH-deep FIFO and leave through a valid/ready stream.
//
// Pipeline: R (read accumulator RAM, forward in-flight sums), A (sum), W
// (write back + FIFO push). Input-to-output latency is 4 cycles.
//
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   bus            : visaccum_stream_if.slave (input stream + output stream)
//   overrun_o      : sticky, a result was dropped on a full FIFO
//   level_o        : FIFO occupancy
//   sat_o          : sticky, a sum clamped (only with VISACCUM_SATURATE_EN)
//
// Build option: define VISACCUM_SATURATE_EN for a saturating adder and the
// sat_o port; otherwise sums wrap modulo 2^OBITS.
// -----------------------------------------------------------------------------
module visaccum_stream #(
    parameter int IBITS  = 7,
    parameter int OBITS  = 36,
    parameter int NSUMS  = 1024,
    parameter int ODEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    visaccum_stream_if.slave        bus,
    output logic                    overrun_o,
    output logic [$clog2(ODEPTH):0] level_o
`ifdef VISACCUM_SATURATE_EN
    ,
    output logic                    sat_o
`endif
);
    localparam int AW = (NSUMS > 1) ? $clog2(NSUMS) : 1;
    localparam int LW = $clog2(ODEPTH);
    localparam int FW = OBITS + 2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NSUMS - 1);
    localparam logic [LW:0]   FULL_CNT  = (LW + 1)'(ODEPTH);

    // address counter
    logic [AW-1:0]    addr_q, addr_d;

    // stage R
    logic             r_valid_q, r_first_q, r_last_q;
    logic [AW-1:0]    r_addr_q;
    logic [IBITS-1:0] r_data_q;

    // stage A
    logic             a_valid_q, a_last_q;
    logic [AW-1:0]    a_addr_q;
    logic [OBITS-1:0] a_sum_q;

    // stage W
    logic             w_valid_q, w_last_q;
    logic [AW-1:0]    w_addr_q;
    logic [OBITS-1:0] w_sum_q;

    logic [OBITS-1:0] ram [0:NSUMS-1];
    logic [OBITS-1:0] operand_s, base_s, sum_s;

    // output FIFO
    logic [FW-1:0]    fifo_mem [0:ODEPTH-1];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW:0]      count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             push_req_s, push_ok_s, pop_s, full_s;
    logic [FW-1:0]    head_s, push_word_s;

    // Address counter next state: advance on every accepted word, wrap at NSUMS-1.
    always_comb begin
        addr_d = addr_q;
        if (bus.s_valid) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Operand select: the youngest in-flight sum for this address beats the RAM,
    // since neither stage A nor stage W has committed its result yet.
    always_comb begin
        operand_s = ram[r_addr_q];
        if (a_valid_q && (a_addr_q == r_addr_q)) begin
            operand_s = a_sum_q;
        end else if (w_valid_q && (w_addr_q == r_addr_q)) begin
            operand_s = w_sum_q;
        end else begin
            operand_s = ram[r_addr_q];
        end
    end

    // First pass overwrites: the previous frame's value is ignored.
    always_comb begin
        base_s = operand_s;
        if (r_first_q) begin
            base_s = '0;
        end else begin
            base_s = operand_s;
        end
    end

`ifdef VISACCUM_SATURATE_EN
    logic [OBITS:0] wide_s;
    logic           clamp_s;
    logic           sat_q;

    // Saturating adder: one extra bit catches the carry, which then clamps.
    always_comb begin
        wide_s  = {1'b0, base_s} + {{(OBITS + 1 - IBITS){1'b0}}, r_data_q};
        sum_s   = wide_s[OBITS-1:0];
        clamp_s = 1'b0;
        if (wide_s[OBITS]) begin
            sum_s   = '1;
            clamp_s = r_valid_q;
        end else begin
            sum_s   = wide_s[OBITS-1:0];
            clamp_s = 1'b0;
        end
    end

    // Sticky clamp flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_q | clamp_s;
        end
    end

    assign sat_o = sat_q;
`else
    // Modular adder: the carry out of the top bit is discarded.
    always_comb begin
        sum_s = base_s + {{(OBITS - IBITS){1'b0}}, r_data_q};
    end
`endif

    // Address counter and R/A/W pipeline registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            r_valid_q <= 1'b0;
            r_first_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_addr_q  <= '0;
            r_data_q  <= '0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_addr_q  <= '0;
            a_sum_q   <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            w_addr_q  <= '0;
            w_sum_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            r_valid_q <= bus.s_valid;
            r_first_q <= bus.s_first;
            r_last_q  <= bus.s_last;
            r_addr_q  <= addr_q;
            r_data_q  <= bus.s_data;
            a_valid_q <= r_valid_q;
            a_last_q  <= r_last_q;
            a_addr_q  <= r_addr_q;
            a_sum_q   <= sum_s;
            w_valid_q <= a_valid_q;
            w_last_q  <= a_last_q;
            w_addr_q  <= a_addr_q;
            w_sum_q   <= a_sum_q;
        end
    end

    // Accumulator RAM write-back; contents are not reset, the first pass rewrites them.
    always_ff @(posedge clock) begin
        if (w_valid_q) begin
            ram[w_addr_q] <= w_sum_q;
        end
    end

    // FIFO control. A pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        push_req_s  = w_valid_q & w_last_q;
        pop_s       = (count_q != '0) & bus.m_ready;
        full_s      = (count_q == FULL_CNT);
        push_ok_s   = push_req_s & (~full_s | pop_s);
        push_word_s = {(w_addr_q == '0), (w_addr_q == LAST_ADDR), w_sum_q};
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + (LW + 1)'(1);
            2'b01:   count_d = count_q - (LW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (push_req_s && !push_ok_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FIFO pointers, occupancy and sticky overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; an empty FIFO masks whatever is stored.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            fifo_mem[wr_ptr_q] <= push_word_s;
        end
    end

    // Output stream: the head word is held until accepted; zeros while empty.
    always_comb begin
        head_s      = fifo_mem[rd_ptr_q];
        bus.m_valid = 1'b0;
        bus.m_first = 1'b0;
        bus.m_last  = 1'b0;
        bus.m_data  = '0;
        if (count_q != '0) begin
            bus.m_valid = 1'b1;
            bus.m_first = head_s[FW-1];
            bus.m_last  = head_s[FW-2];
            bus.m_data  = head_s[OBITS-1:0];
        end else begin
            bus.m_valid = 1'b0;
            bus.m_first = 1'b0;
            bus.m_last  = 1'b0;
            bus.m_data  = '0;
        end
    end

    assign overrun_o = overrun_q;
    assign level_o   = count_q;
endmodule

// File: tb/tb_visaccum_stream.sv
// -----------------------------------------------------------------------------
// tb_visaccum_stream
// Two accumulator instances: A (NSUMS=4, OBITS=8, ODEPTH=4) for multi-pass
// sums, wrap/saturation, overrun, stalls and reset mid-frame; B (NSUMS=2,
// OBITS=12) for back-to-back same-address hazards. A reference accumulator
// pushes expected output words into per-instance queues when a last-pass word
// is driven; monitors compare the head of the queue whenever m_valid is high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_visaccum_stream;
    localparam int A_IBITS = 7, A_OBITS = 8,  A_NSUMS = 4, A_ODEPTH = 4;
    localparam int B_IBITS = 7, B_OBITS = 12, B_NSUMS = 2, B_ODEPTH = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    visaccum_stream_if #(.IBITS(A_IBITS), .OBITS(A_OBITS)) bus_a ();
    visaccum_stream_if #(.IBITS(B_IBITS), .OBITS(B_OBITS)) bus_b ();

    logic       ovr_a, ovr_b;
    logic [2:0] lvl_a, lvl_b;
`ifdef VISACCUM_SATURATE_EN
    logic       sat_a, sat_b;
`endif

    visaccum_stream #(.IBITS(A_IBITS), .OBITS(A_OBITS), .NSUMS(A_NSUMS), .ODEPTH(A_ODEPTH)) u_dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus_a),
        .overrun_o (ovr_a),
        .level_o   (lvl_a)
`ifdef VISACCUM_SATURATE_EN
        ,
        .sat_o     (sat_a)
`endif
    );

    visaccum_stream #(.IBITS(B_IBITS), .OBITS(B_OBITS), .NSUMS(B_NSUMS), .ODEPTH(B_ODEPTH)) u_dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus_b),
        .overrun_o (ovr_b),
        .level_o   (lvl_b)
`ifdef VISACCUM_SATURATE_EN
        ,
        .sat_o     (sat_b)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    longint unsigned acc_a [A_NSUMS];
    longint unsigned acc_b [B_NSUMS];
    int              addr_a = 0, addr_b = 0;
    logic [63:0]     q_a [$];
    logic [63:0]     q_b [$];
    bit              cap_mode  = 1'b0;
    bit              exp_sat_a = 1'b0, exp_sat_b = 1'b0;
    int              rdy_mode_a = 0, rdy_mode_b = 0;   // 0: ready, 1: stalled, 2: toggling
    int              lat_mark = -1, rise_cyc = -1;
    bit              lat_arm  = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one input word after `gap` idle cycles and update the model.
    task automatic drive_word(input bit sel, input bit f, input bit l, input int unsigned d, input int gap);
        longint unsigned prev, s, maxv;
        int a;
        repeat (gap) begin
            @(posedge clock); #1;
            if (sel) bus_b.s_valid = 1'b0; else bus_a.s_valid = 1'b0;
        end
        @(posedge clock); #1;
        if (!sel) begin
            bus_a.s_valid = 1'b1; bus_a.s_first = f; bus_a.s_last = l;
            bus_a.s_data  = A_IBITS'(d);
            a = addr_a; prev = acc_a[a]; maxv = (64'd1 << A_OBITS) - 64'd1;
            if (l && lat_mark < 0) lat_mark = cyc;
        end else begin
            bus_b.s_valid = 1'b1; bus_b.s_first = f; bus_b.s_last = l;
            bus_b.s_data  = B_IBITS'(d);
            a = addr_b; prev = acc_b[a]; maxv = (64'd1 << B_OBITS) - 64'd1;
        end
        s = (f ? 64'd0 : prev) + 64'(d);
        if (s > maxv) begin
`ifdef VISACCUM_SATURATE_EN
            s = maxv;
            if (sel) exp_sat_b = 1'b1; else exp_sat_a = 1'b1;
`else
            s = s & maxv;
`endif
        end
        if (!sel) begin
            acc_a[a] = s;
            addr_a   = (a + 1) % A_NSUMS;
            if (l && (!cap_mode || q_a.size() < A_ODEPTH))
                q_a.push_back({30'b0, (a == 0), (a == A_NSUMS - 1), 32'(s)});
        end else begin
            acc_b[a] = s;
            addr_b   = (a + 1) % B_NSUMS;
            if (l) q_b.push_back({30'b0, (a == 0), (a == B_NSUMS - 1), 32'(s)});
        end
    endtask

    task automatic idle(input int n);
        @(posedge clock); #1;
        bus_a.s_valid = 1'b0; bus_a.s_first = 1'b0; bus_a.s_last = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_first = 1'b0; bus_b.s_last = 1'b0;
        repeat (n) @(posedge clock);
    endtask

    // Wait (bounded) until every expected word has left and the FIFO is empty.
    task automatic drain(input bit sel);
        int n = 0;
        while (n < 400 && (sel ? (q_b.size() != 0 || lvl_b != 3'd0)
                               : (q_a.size() != 0 || lvl_a != 3'd0))) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        if (sel) check_val("b_drain_left", 64'(q_b.size()), 64'd0);
        else     check_val("a_drain_left", 64'(q_a.size()), 64'd0);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // m_ready drivers.
    initial begin
        bus_a.m_ready = 1'b1;
        bus_b.m_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            case (rdy_mode_a)
                1:       bus_a.m_ready = 1'b0;
                2:       bus_a.m_ready = ~bus_a.m_ready;
                default: bus_a.m_ready = 1'b1;
            endcase
            case (rdy_mode_b)
                1:       bus_b.m_ready = 1'b0;
                2:       bus_b.m_ready = ~bus_b.m_ready;
                default: bus_b.m_ready = 1'b1;
            endcase
        end
    end

    // Output monitor A: the head word must match while valid, stalled or not.
    initial begin
        bit prev_v = 1'b0;
        forever begin
            @(negedge clock);
            if (bus_a.m_valid) begin
                if (lat_arm && !prev_v) begin
                    rise_cyc = cyc;
                    lat_arm  = 1'b0;
                end
                if (q_a.size() == 0) begin
                    check_val("a_unexpected_word", 64'(bus_a.m_valid), 64'd0);
                end else begin
                    check_val("a_out", {30'b0, bus_a.m_first, bus_a.m_last, 24'b0, bus_a.m_data}, q_a[0]);
                    if (bus_a.m_ready) void'(q_a.pop_front());
                end
            end
            prev_v = bus_a.m_valid;
        end
    end

    // Output monitor B.
    initial forever begin
        @(negedge clock);
        if (bus_b.m_valid) begin
            if (q_b.size() == 0) begin
                check_val("b_unexpected_word", 64'(bus_b.m_valid), 64'd0);
            end else begin
                check_val("b_out", {30'b0, bus_b.m_first, bus_b.m_last, 20'b0, bus_b.m_data}, q_b[0]);
                if (bus_b.m_ready) void'(q_b.pop_front());
            end
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned vals [4];

    initial begin
        bus_a.s_valid = 1'b0; bus_a.s_first = 1'b0; bus_a.s_last = 1'b0; bus_a.s_data = '0;
        bus_b.s_valid = 1'b0; bus_b.s_first = 1'b0; bus_b.s_last = 1'b0; bus_b.s_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_m_valid", 64'(bus_a.m_valid), 64'd0);
        check_val("rst_m_first", 64'(bus_a.m_first), 64'd0);
        check_val("rst_m_last",  64'(bus_a.m_last),  64'd0);
        check_val("rst_m_data",  64'(bus_a.m_data),  64'd0);
        check_val("rst_level",   64'(lvl_a),         64'd0);
        check_val("rst_overrun", 64'(ovr_a),         64'd0);
        check_val("rst_b_valid", 64'(bus_b.m_valid), 64'd0);
`ifdef VISACCUM_SATURATE_EN
        check_val("rst_sat",     64'(sat_a),         64'd0);
`endif
        reset_n = 1'b1;

        // three passes of 10,20,30,40 -> 30,60,90,120; latency of first result
        vals = '{10, 20, 30, 40};
        lat_arm = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++)
                drive_word(1'b0, (p == 0), (p == 2), vals[i], 0);
        idle(1);
        drain(1'b0);
        check_val("a_latency", 64'(rise_cyc - lat_mark), 64'd4);
        check_val("a_overrun_clean", 64'(ovr_a), 64'd0);

        // toggling m_ready while results drain, with input gaps
        rdy_mode_a = 2;
        vals = '{3, 6, 9, 12};
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++)
                drive_word(1'b0, (p == 0), (p == 1), vals[i], $urandom_range(0, 1));
        idle(1);
        drain(1'b0);
        rdy_mode_a = 0;

        // three passes of 127: wraps to 125, or clamps at 255
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++)
                drive_word(1'b0, (p == 0), (p == 2), 127, 0);
        idle(1);
        drain(1'b0);
`ifdef VISACCUM_SATURATE_EN
        check_val("a_sat_flag", 64'(sat_a), 64'(exp_sat_a));
`endif

        // overrun: 8 single-pass words into a 4-deep FIFO with no reader
        rdy_mode_a = 1;
        idle(2);
        cap_mode = 1'b1;
        for (int i = 1; i <= 8; i++)
            drive_word(1'b0, 1'b1, 1'b1, i, 0);
        idle(6);
        @(negedge clock);
        check_val("a_level_full", 64'(lvl_a), 64'd4);
        check_val("a_overrun_set", 64'(ovr_a), 64'd1);
        rdy_mode_a = 0;
        drain(1'b0);
        cap_mode = 1'b0;
        check_val("a_overrun_sticky", 64'(ovr_a), 64'd1);

        // reset in the middle of pass 2, then a fresh two-pass frame of 5s
        for (int i = 0; i < 4; i++) drive_word(1'b0, 1'b1, 1'b0, 7, 0);
        drive_word(1'b0, 1'b0, 1'b0, 7, 0);
        drive_word(1'b0, 1'b0, 1'b0, 7, 0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        bus_a.s_valid = 1'b0;
        addr_a = 0; addr_b = 0; exp_sat_a = 1'b0; exp_sat_b = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_val("a_overrun_after_rst", 64'(ovr_a), 64'd0);
        check_val("a_level_after_rst", 64'(lvl_a), 64'd0);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++)
                drive_word(1'b0, (p == 0), (p == 1), 5, 0);
        idle(1);
        drain(1'b0);
        check_val("a_overrun_fresh", 64'(ovr_a), 64'd0);

        // NSUMS=2 back-to-back: every word hits an address still in flight
        for (int p = 0; p < 3; p++) begin
            drive_word(1'b1, (p == 0), (p == 2), 2 * p + 1, 0);
            drive_word(1'b1, (p == 0), (p == 2), 2 * p + 2, 0);
        end
        idle(1);
        drain(1'b1);

        // same frame with random input gaps
        for (int p = 0; p < 3; p++) begin
            drive_word(1'b1, (p == 0), (p == 2), 2 * p + 1, $urandom_range(0, 3));
            drive_word(1'b1, (p == 0), (p == 2), 2 * p + 2, $urandom_range(0, 3));
        end
        idle(1);
        drain(1'b1);
        check_val("b_overrun_clean", 64'(ovr_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
